// File: rtl/operand_issue_stage.sv
// operand_issue_stage: fetches operands for one instruction at a time from an
// 8 x DW register file, hands them to an external ALU, captures the ALU result
// and retires it, writing back to rd when allowed.
// Build option: define ILLEGAL_OP_TRAP_EN to make illegal opcodes raise a
// sticky illegal_err that blocks further instructions until reset; otherwise
// illegal opcodes retire as no-ops and illegal_err is tied low.
module operand_issue_stage #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [2:0]    aluControl,
  output logic [DW-1:0] rs1Value,
  output logic [DW-1:0] rs2Value,
  input  logic          regWriteEnable,
  input  logic [DW-1:0] rdValue,
  output logic          retire_valid,
  output logic [DW-1:0] retire_data,
  output logic          illegal_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [15:4]   instr_q;
  logic [DW-1:0] regs_q [8];
  logic [2:0]    aluControl_q;
  logic [DW-1:0] rs1Value_q, rs2Value_q;
  logic [DW-1:0] result_q;
  logic          resultWe_q;

  logic [2:0] opQ, rdQ, rs1Q, rs2Q;
  logic       opIllegal;
  logic       accept;
  logic       doWrite;
  logic       readyRaw;

  assign opQ  = instr_q[15:13];
  assign rdQ  = instr_q[12:10];
  assign rs1Q = instr_q[9:7];
  assign rs2Q = instr_q[6:4];

  assign opIllegal = (opQ > 3'b100);
  assign accept    = instr_valid && instr_ready;
  assign doWrite   = (state_q == WB) && resultWe_q && (rdQ != 3'd0) && !opIllegal;
  assign readyRaw  = (state_q == IDLE) && !reset;

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q;

  // Sticky trap flag, raised when an illegal instruction leaves WB
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if ((state_q == WB) && opIllegal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_err = illegal_q;
  assign instr_ready = readyRaw && !illegal_q;
`else
  assign illegal_err = 1'b0;
  assign instr_ready = readyRaw;
`endif

  // Next-state logic: a fixed four-step walk once an instruction is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and instruction latch on acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= instr[15:4];
      end
    end
  end

  // Operand fetch at the end of READ; held stable until the next READ
  always_ff @(posedge clk) begin
    if (reset) begin
      aluControl_q <= '0;
      rs1Value_q   <= '0;
      rs2Value_q   <= '0;
    end else if (state_q == READ) begin
      aluControl_q <= opQ;
      rs1Value_q   <= regs_q[rs1Q];
      rs2Value_q   <= regs_q[rs2Q];
    end
  end

  // Capture the ALU result and its write request at the end of EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q   <= '0;
      resultWe_q <= 1'b0;
    end else if (state_q == EXEC) begin
      result_q   <= rdValue;
      resultWe_q <= regWriteEnable;
    end
  end

  // Register file; r0 is never written so it always reads zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else if (doWrite) begin
      regs_q[rdQ] <= result_q;
    end
  end

  // Outputs are forced to zero while reset is held, even before the first edge
  assign aluControl   = reset ? 3'd0 : aluControl_q;
  assign rs1Value     = reset ? '0 : rs1Value_q;
  assign rs2Value     = reset ? '0 : rs2Value_q;
  assign retire_valid = (state_q == WB) && !reset;
  assign retire_data  = reset ? '0 : result_q;

endmodule
